stream_fifo: RTL and testbench
==============================

# stream_fifo

Parametrised synchronous valid/ready stream FIFO; the next generation of the team's 32-bit/16-entry stream buffer. It adds configurable width and depth, use of all DEPTH entries, a live fill level, programmable almost-full/almost-empty flags, a synchronous flush, and an optional registered output stage. It sits between any two single-clock valid/ready stream stages and decouples producer and consumer.

## Interface
- DATA_W, 32, payload width in bits (≥1)
- DEPTH, 16, storage entries; power of two, ≥2
- AFULL_TH, DEPTH-2, almost_full asserts when level ≥ AFULL_TH
- AEMPTY_TH, 1, almost_empty asserts when level ≤ AEMPTY_TH
- Let LVL_W = $clog2(CAP+1), where CAP is the total capacity (see Configuration).
- sys_clk  in  1  single clock; all logic on rising edge
- sys_rst  in  1  reset; **synchronous, active-high**
- flush  in  1  synchronous clear of contents; data RAM untouched
- rx_data  in  DATA_W  producer payload
- rx_valid  in  1  producer has data
- rx_ready  out  1  FIFO can accept
- tx_data  out  DATA_W  consumer payload
- tx_valid  out  1  FIFO has data
- tx_ready  in  1  consumer accepts
- level  out  LVL_W  entries currently held
- almost_full  out  1  level ≥ AFULL_TH
- almost_empty  out  1  level ≤ AEMPTY_TH

## Operation
- Push = rx_valid & rx_ready. Pop = tx_valid & tx_ready.
- Pointers are $clog2(DEPTH)+1 bits wide; the MSB is the wrap bit.
  - full: addresses equal and wrap bits differ.
  - empty: pointers equal.
  - All DEPTH entries are usable.
- rx_ready = !full & !sys_rst & !flush.
- tx_valid = !empty, subject to the output stage described in Configuration.
- Push writes rx_data at the write pointer. Pop advances the read pointer. Pointers wrap modulo DEPTH with no gap.
- Simultaneous push and pop:
  - level is unchanged.
  - Both pointers advance.
  - Legal at any non-full, non-empty level.
  - When full, rx_ready=0, so only the pop occurs.
  - When empty, tx_valid=0, so only the push occurs. There is no same-cycle bypass.
- level is registered and changes by exactly +1, −1 or 0 per cycle. It never exceeds CAP and never underflows.
- almost_full and almost_empty are combinational from level.
- Priority: sys_rst > flush > push/pop.
- flush clears pointers, level and the output stage in one cycle. Any push or pop in the same cycle is discarded.
- Data order is strictly FIFO. tx_data holds while tx_valid=1 and tx_ready=0.

## Timing
- During and after reset: level=0, tx_valid=0, almost_empty=1, almost_full=(AFULL_TH==0).
  - rx_ready=0 while sys_rst=1.
  - rx_ready=1 in the first cycle after deassertion.
- Reset mid-stream: all contents are lost at the next edge. tx_data is don't-care while tx_valid=0.
- Write-to-read latency, no macro: a word pushed at edge N gives tx_valid=1 after edge N.
- Full-to-ready recovery: a pop at edge N gives rx_ready=1 after edge N, which allows a push in the following cycle.
- Sustained throughput: one word per cycle in each direction.

## Configuration
- STREAM_FIFO_OUT_REG_EN
- Defined:
  - tx_data and tx_valid come from a one-entry output register loaded from RAM when the register is empty or being popped.
  - CAP = DEPTH+1.
  - Write-to-read latency is 2 edges.
  - tx_data is a flop output with no RAM-to-output combinational path.
  - level counts RAM entries plus the output register.
- Undefined:
  - First-word-fall-through; tx_data reads RAM at the read pointer combinationally.
  - CAP = DEPTH.
  - Latency is 1 edge.
- Handshake rules, flush and reset behaviour are identical in both builds.

## Test plan
- DATA_W=8, DEPTH=4, no macro:
  - Push 0x11, 0x22, 0x33, 0x44 back-to-back. Required: rx_ready=0 and level=4 after the 4th edge; almost_full=1 from level 2.
  - Then pop 4 with tx_ready=1. Required: outputs 0x11..0x44 in order; level=0; tx_valid=0.
- Full plus simultaneous activity: at level=4 hold rx_valid=1 and tx_ready=1 for 1 cycle. Required: only the pop occurs, level=3, the next cycle accepts a push.
- Wrap-around: 10 push/pop pairs streaming, 1 per cycle, data 0..9. Required: level stays at 1, no data lost or reordered across the pointer wrap.
- Flush with rx_valid=1 at level=3. Required:
  - level=0 and tx_valid=0 next cycle; the flushed-cycle word is not stored.
  - A subsequent push of 0xA5 is output first.
- Reset with sys_rst=1 for 2 cycles mid-stream at level=2. Required:
  - rx_ready=0 during reset; level=0.
  - rx_ready=1 the first cycle after.
- With STREAM_FIFO_OUT_REG_EN:
  - Single push of 0x5A. Required: tx_valid rises 2 edges later.
  - Fill with tx_ready=0. Required: 5 words accepted, level=5.

Source files
------------

// File: rtl/stream_fifo.sv
// stream_fifo: parametrised single-clock valid/ready FIFO with fill level and almost-full/empty flags.
// Define STREAM_FIFO_OUT_REG_EN to add a registered output stage (capacity DEPTH+1, latency 2).
module stream_fifo #(
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int AFULL_TH  = DEPTH - 2,
    parameter int AEMPTY_TH = 1,
`ifdef STREAM_FIFO_OUT_REG_EN
    localparam int CAP      = DEPTH + 1,
`else
    localparam int CAP      = DEPTH,
`endif
    localparam int LVL_W    = $clog2(CAP + 1)
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              flush,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic [LVL_W-1:0]  level,
    output logic              almost_full,
    output logic              almost_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0]    PTR_ONE = {{AW{1'b0}}, 1'b1};
    localparam logic [LVL_W-1:0] LVL_ONE = {{(LVL_W-1){1'b0}}, 1'b1};

    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q;
    logic [PW-1:0]     rd_ptr_d;
    logic [LVL_W-1:0]  level_q;
    logic [LVL_W-1:0]  level_d;
    logic [DATA_W-1:0] ram_q [DEPTH];

    logic ram_full_s;
    logic ram_empty_s;
    logic push_s;
    logic pop_s;
    logic ram_rd_s;

    assign ram_full_s  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign ram_empty_s = (wr_ptr_q == rd_ptr_q);

    assign rx_ready = !ram_full_s && !sys_rst && !flush;
    assign push_s   = rx_valid && rx_ready;
    assign pop_s    = tx_valid && tx_ready;

`ifdef STREAM_FIFO_OUT_REG_EN
    logic              out_valid_q;
    logic              out_valid_d;
    logic [DATA_W-1:0] out_data_q;
    logic [DATA_W-1:0] out_data_d;

    // The output register refills from RAM whenever it is empty or being drained this cycle.
    assign ram_rd_s = !ram_empty_s && (!out_valid_q || tx_ready);

    // Next-state for the output register.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (ram_rd_s) begin
            out_valid_d = 1'b1;
            out_data_d  = ram_q[rd_ptr_q[AW-1:0]];
        end else if (pop_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Output register flops.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= {DATA_W{1'b0}};
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign tx_valid = out_valid_q;
    assign tx_data  = out_data_q;
`else
    // First-word-fall-through: the head entry is presented straight from RAM.
    assign ram_rd_s = pop_s;
    assign tx_valid = !ram_empty_s;
    assign tx_data  = ram_q[rd_ptr_q[AW-1:0]];
`endif

    // Pointer next-state; flush overrides any same-cycle push or RAM read.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = {PW{1'b0}};
            rd_ptr_d = {PW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (ram_rd_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Level tracks external push/pop only, so the internal RAM-to-register move is level-neutral.
    always_comb begin
        level_d = level_q;
        if (flush) begin
            level_d = {LVL_W{1'b0}};
        end else if (push_s && !pop_s) begin
            level_d = level_q + LVL_ONE;
        end else if (!push_s && pop_s) begin
            level_d = level_q - LVL_ONE;
        end else begin
            level_d = level_q;
        end
    end

    // Control state flops.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            level_q  <= {LVL_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Data storage; no reset so contents survive flush and stay RAM-mappable.
    always_ff @(posedge sys_clk) begin
        if (push_s) begin
            ram_q[wr_ptr_q[AW-1:0]] <= rx_data;
        end
    end

    assign level        = level_q;
    assign almost_full  = (32'(level_q) >= 32'(AFULL_TH));
    assign almost_empty = (32'(level_q) <= 32'(AEMPTY_TH));

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo (DATA_W=8, DEPTH=4): vector table for the FWFT build,
// plus latency / fill / drain sequences that adapt to STREAM_FIFO_OUT_REG_EN.
module tb_stream_fifo;

`ifdef STREAM_FIFO_OUT_REG_EN
    localparam int CAP = 5;
    localparam int LAT = 2;
`else
    localparam int CAP = 4;
    localparam int LAT = 1;
`endif

    logic       clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       flush = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic [2:0] level;
    logic       almost_full;
    logic       almost_empty;

    int checks = 0;
    int errors = 0;

    stream_fifo #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .sys_clk      (clk),
        .sys_rst      (sys_rst),
        .flush        (flush),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .level        (level),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       fl;
        logic       rv;
        logic [7:0] d;
        logic       tr;
        logic       e_rdy;
        logic       e_tv;
        logic [7:0] e_d;
        logic [2:0] e_lvl;
        logic       e_af;
        logic       e_ae;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic fl, input logic rv, input logic [7:0] d,
                                input logic tr, input logic e_rdy, input logic e_tv, input logic [7:0] e_d,
                                input logic [2:0] e_lvl, input logic e_af, input logic e_ae);
        vec_t v;
        v.rst = rst; v.fl = fl; v.rv = rv; v.d = d; v.tr = tr;
        v.e_rdy = e_rdy; v.e_tv = e_tv; v.e_d = e_d; v.e_lvl = e_lvl; v.e_af = e_af; v.e_ae = e_ae;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges;
        int acc;
        int idx;
        int cyc;

`ifndef STREAM_FIFO_OUT_REG_EN
        // Each row: inputs held this cycle, outputs expected before the next edge.
        //            rst   fl    rv    d      tr    rdy   tv    data   lvl   af    ae
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1, 1'b0));
        // full with push and pop both requested: only the pop happens
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 1'b1, 8'h11, 3'd4, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 8'h22, 3'd3, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 3'd4, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd3, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 3'd2, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h77, 3'd1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1));
        // streaming 0..9 across the pointer wrap
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1));
        for (int k = 1; k < 10; k++) begin
            vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'(k), 1'b1, 1'b1, 1'b1, 8'(k - 1), 3'd1, 1'b0, 1'b1));
        end
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h09, 3'd1, 1'b0, 1'b1));
        // fill to 3, then flush with a push and pop pending
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hC1, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hC2, 1'b0, 1'b1, 1'b1, 8'hC1, 3'd1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 1'b1, 8'hC1, 3'd2, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b1, 8'hC1, 3'd3, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'hB6, 1'b0, 1'b1, 1'b1, 8'hA5, 3'd1, 1'b0, 1'b1));
        // two-cycle reset at level 2
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 3'd2, 1'b1, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h5A, 3'd1, 1'b0, 1'b1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            sys_rst  = vecs[i].rst;
            flush    = vecs[i].fl;
            rx_valid = vecs[i].rv;
            rx_data  = vecs[i].d;
            tx_ready = vecs[i].tr;
            #1;
            check($sformatf("v%0d rx_ready", i), 32'(rx_ready), 32'(vecs[i].e_rdy));
            check($sformatf("v%0d tx_valid", i), 32'(tx_valid), 32'(vecs[i].e_tv));
            check($sformatf("v%0d level", i), 32'(level), 32'(vecs[i].e_lvl));
            check($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(vecs[i].e_af));
            check($sformatf("v%0d almost_empty", i), 32'(almost_empty), 32'(vecs[i].e_ae));
            if (vecs[i].e_tv) begin
                check($sformatf("v%0d tx_data", i), 32'(tx_data), 32'(vecs[i].e_d));
            end
        end
`endif

        // Reset, then measure write-to-read latency of a single word.
        @(negedge clk);
        sys_rst = 1'b1; flush = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        sys_rst = 1'b0;
        #1;
        check("post-reset level", 32'(level), 32'd0);
        check("post-reset tx_valid", 32'(tx_valid), 32'd0);
        check("post-reset rx_ready", 32'(rx_ready), 32'd1);
        check("post-reset almost_empty", 32'(almost_empty), 32'd1);

        rx_valid = 1'b1;
        rx_data  = 8'h5A;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        edges = 1;
        while (!tx_valid && edges < 8) begin
            @(posedge clk);
            #1;
            edges++;
        end
        check("write-to-read latency", 32'(edges), 32'(LAT));
        check("latency word", 32'(tx_data), 32'h5A);

        @(negedge clk);
        tx_ready = 1'b1;
        #1;
        check("latency word valid", 32'(tx_valid), 32'd1);
        @(negedge clk);
        tx_ready = 1'b0;
        #1;
        check("single drain level", 32'(level), 32'd0);
        check("single drain tx_valid", 32'(tx_valid), 32'd0);

        // Fill with the consumer stalled; count accepted words.
        acc = 0;
        for (int c = 0; c < CAP + 3; c++) begin
            @(negedge clk);
            rx_valid = 1'b1;
            rx_data  = 8'(8'h80 + acc);
            #1;
            if (rx_ready) begin
                acc++;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        check("fill accepted words", 32'(acc), 32'(CAP));
        check("fill level", 32'(level), 32'(CAP));
        check("fill rx_ready", 32'(rx_ready), 32'd0);
        check("fill almost_full", 32'(almost_full), 32'd1);

        // Drain at full rate and verify order.
        tx_ready = 1'b1;
        idx = 0;
        cyc = 0;
        while (idx < CAP && cyc < 20) begin
            if (tx_valid) begin
                check($sformatf("drain word %0d", idx), 32'(tx_data), 32'(8'h80 + idx));
                idx++;
            end
            @(negedge clk);
            #1;
            cyc++;
        end
        check("drain count", 32'(idx), 32'(CAP));
        check("drain level", 32'(level), 32'd0);
        check("drain tx_valid", 32'(tx_valid), 32'd0);
        check("drain almost_empty", 32'(almost_empty), 32'd1);
        tx_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
